reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
// - Per-FU reservation station; receive end of the dispatcher->RS interface.
// - Accepts one INST_RS per cycle on load, reports fullness back to the dispatcher.
// - Snoops the CDB to wake up operands; issues the oldest fully-ready entry to its FU via valid/ready.
// - One instance per FU class (ALU, MULT, BTU, LSU).
// PARAMETERS
// - RS_SIZE  default 4  number of entries (>=2)
// PORTS
// - clk            in   1                  clock, rising edge
// - reset          in   1                  asynchronous, active-low (asserted when 0)
// - load           in   1                  dispatcher writes inst_rs this cycle (RS_load[fu] bit)
// - inst_rs        in   INST_RS            fu, func, tag_dest, tag_src1/2, ready_src1/2, value_src1/2, imm, pc
// - is_full        out  1                  no free entry (RS_is_full[fu] bit)
// - cdb_valid      in   1                  CDB broadcast valid
// - cdb_tag        in   ROB_TAG_LEN        producing ROB tag
// - cdb_value      in   XLEN               broadcast result
// - squash         in   1                  mispredict flush; clears all entries
// - issue_valid    out  1                  an entry is ready to issue
// - issue_ready    in   1                  FU accepts this cycle
// - issue_func     out  ALU_FUNC           func of issued entry
// - issue_tag      out  ROB_TAG_LEN        tag_dest of issued entry
// - issue_src1     out  XLEN               operand 1 value
// - issue_src2     out  XLEN               operand 2 value
// - issue_imm      out  XLEN               imm (BTU use)
// - issue_pc       out  XLEN               pc (BTU use)
// BEHAVIOUR
// - Reset (reset==0, async): all entries invalid; is_full=0; issue_valid=0; issue_* = 0.
// - Entry state: valid, ready1/2, tag1/2, value1/2, func, tag_dest, imm, pc, age order.
// - Occupancy count drives is_full = (count==RS_SIZE).
//   - is_full derives from registered state only; no same-cycle free-slot forwarding.
// - Load accepted iff load && !is_full && !squash.
//   - Entry is written into the lowest-index free slot at the edge.
//   - load while is_full is ignored; no state change, no error.
// - CDB capture, at the edge, for every valid entry and each source with ready==0 && tag==cdb_tag && cdb_valid:
//   - value <= cdb_value; ready <= 1.
// - Load+CDB in the same cycle: if an incoming source is not ready and its tag matches cdb_tag, the entry is written already ready with cdb_value.
//   - Mandatory: prevents a lost wakeup.
// - Issue selection: among entries with valid && ready1 && ready2, pick the oldest by allocation order.
//   - Combinational; issue_valid=1 when any exists.
//   - issue_* show the selected entry, and are 0 when issue_valid=0.
// - Issue fire = issue_valid && issue_ready; the selected entry is freed at the edge.
// - Fire and load in the same cycle when not full: both occur; count unchanged.
// - Fire while full: slot frees at the edge; is_full drops next cycle. Same-cycle load is still rejected.
// - issue_ready==0: selection may change next cycle if an older entry wakes. No payload-hold guarantee is required of the FU.
// - Squash: synchronous, highest priority.
//   - issue_valid forced 0 that cycle; load and CDB are ignored.
//   - All entries invalid after the edge.
// - Age order is preserved across wrap-around and any mix of frees; oldest means earliest accepted load.
// - Reset asserted mid-operation clears everything immediately; the first load after deassert is accepted normally.
// CONFIGURATION
// - RS_WAKEUP_ISSUE_EN defined: an entry whose last missing operand matches the current CDB broadcast counts as ready this cycle.
//   - It may issue immediately, with issue_src* taken from cdb_value (same-cycle bypass).
// - Not defined: a woken entry becomes issuable the cycle after capture; issue_src* always come from entry registers.
// TESTING
// - Reset, load ALU entry (both srcs ready, 5 and 7, tag_dest=3), issue_ready=1:
//   - issue_valid=1 the next cycle, with src1=5, src2=7, tag=3.
//   - Entry gone after fire.
// - Fill all 4 entries with tag_src1=9, ready_src1=0:
//   - is_full=1 and a 5th load is ignored.
//   - CDB tag=9 value=0x42 -> all four wake; they issue in load order over 4 cycles with src1=0x42.
// - Load with tag_src2=6 not ready in the same cycle as cdb_valid, cdb_tag=6, value=0x11:
//   - The entry is issuable next cycle with src2=0x11.
// - Wakeup: two ready entries loaded in the order A then B, issue_ready=0 for 3 cycles, then 1:
//   - A issues first, then B.
// - Wakeup: an older waiting entry woken by CDB pre-empts a younger ready one.
// - Squash with 3 valid entries:
//   - issue_valid=0 that cycle; next cycle is_full=0 and no entry issues.
//   - A load in the squash cycle is dropped.
// - Bypass: entry waiting on tag=2, CDB tag=2 value=0x99, issue_ready=1:
//   - With RS_WAKEUP_ISSUE_EN, issue fires that cycle with src=0x99.
//   - Without it, issue fires one cycle later.

Source files
------------

// File: rtl/reservation_station.sv
// Per-FU reservation station: age-ordered entries with CDB wakeup and oldest-ready issue.
// Optional macro RS_WAKEUP_ISSUE_EN lets an entry woken by the current CDB broadcast issue in the same cycle.
package rs_pkg;
    localparam int XLEN         = 32;
    localparam int ROB_TAG_LEN  = 5;
    localparam int ALU_FUNC_LEN = 4;

    typedef logic [ALU_FUNC_LEN-1:0] alu_func_t;

    typedef struct packed {
        logic [1:0]             fu;
        alu_func_t              func;
        logic [ROB_TAG_LEN-1:0] tag_dest;
        logic [ROB_TAG_LEN-1:0] tag_src1;
        logic [ROB_TAG_LEN-1:0] tag_src2;
        logic                   ready_src1;
        logic                   ready_src2;
        logic [XLEN-1:0]        value_src1;
        logic [XLEN-1:0]        value_src2;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
    } inst_rs_t;
endpackage

module reservation_station
    import rs_pkg::*;
#(
    parameter int RS_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  inst_rs_t               inst_rs,
    output logic                   is_full,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_value,
    input  logic                   squash,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output alu_func_t              issue_func,
    output logic [ROB_TAG_LEN-1:0] issue_tag,
    output logic [XLEN-1:0]        issue_src1,
    output logic [XLEN-1:0]        issue_src2,
    output logic [XLEN-1:0]        issue_imm,
    output logic [XLEN-1:0]        issue_pc
);
    typedef struct packed {
        alu_func_t              func;
        logic [ROB_TAG_LEN-1:0] tag_dest;
        logic [ROB_TAG_LEN-1:0] tag1;
        logic [ROB_TAG_LEN-1:0] tag2;
        logic                   rdy1;
        logic                   rdy2;
        logic [XLEN-1:0]        val1;
        logic [XLEN-1:0]        val2;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
    } entry_t;

    entry_t [RS_SIZE-1:0]              ent_q, ent_d;
    logic   [RS_SIZE-1:0]              valid_q, valid_d;
    // older_q[i][j] set means entry j was accepted before entry i
    logic   [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;

    logic [RS_SIZE-1:0]           wake1, wake2, cand, sel, alloc_oh;
    logic [RS_SIZE-1:0][XLEN-1:0] op1, op2;
    logic                         load_acc, fire, in_wake1, in_wake2;
    logic                         unused_fu;

    assign unused_fu = ^inst_rs.fu;
    assign is_full   = &valid_q;
    assign load_acc  = load && !is_full && !squash;
    assign fire      = issue_valid && issue_ready;
    assign in_wake1  = cdb_valid && !inst_rs.ready_src1 && (inst_rs.tag_src1 == cdb_tag);
    assign in_wake2  = cdb_valid && !inst_rs.ready_src2 && (inst_rs.tag_src2 == cdb_tag);

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        cand  = '0;
        op1   = '0;
        op2   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1[i] = cdb_valid && !ent_q[i].rdy1 && (ent_q[i].tag1 == cdb_tag);
            wake2[i] = cdb_valid && !ent_q[i].rdy2 && (ent_q[i].tag2 == cdb_tag);
`ifdef RS_WAKEUP_ISSUE_EN
            cand[i] = valid_q[i] && (ent_q[i].rdy1 || wake1[i]) && (ent_q[i].rdy2 || wake2[i]);
            op1[i]  = ent_q[i].rdy1 ? ent_q[i].val1 : cdb_value;
            op2[i]  = ent_q[i].rdy2 ? ent_q[i].val2 : cdb_value;
`else
            cand[i] = valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
            op1[i]  = ent_q[i].val1;
            op2[i]  = ent_q[i].val2;
`endif
        end
    end

    // Oldest candidate: no other candidate is older than it
    always_comb begin
        sel         = '0;
        issue_valid = 1'b0;
        issue_func  = '0;
        issue_tag   = '0;
        issue_src1  = '0;
        issue_src2  = '0;
        issue_imm   = '0;
        issue_pc    = '0;
        for (int i = 0; i < RS_SIZE; i++)
            sel[i] = cand[i] && ((cand & older_q[i]) == '0);
        if (|sel && !squash) begin
            issue_valid = 1'b1;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (sel[i]) begin
                    issue_func = issue_func | ent_q[i].func;
                    issue_tag  = issue_tag  | ent_q[i].tag_dest;
                    issue_src1 = issue_src1 | op1[i];
                    issue_src2 = issue_src2 | op2[i];
                    issue_imm  = issue_imm  | ent_q[i].imm;
                    issue_pc   = issue_pc   | ent_q[i].pc;
                end
            end
        end
    end

    always_comb begin
        alloc_oh = '0;
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        older_d = older_q;
        if (squash) begin
            valid_d = '0;
            older_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && wake1[i]) begin
                    ent_d[i].rdy1 = 1'b1;
                    ent_d[i].val1 = cdb_value;
                end
                if (valid_q[i] && wake2[i]) begin
                    ent_d[i].rdy2 = 1'b1;
                    ent_d[i].val2 = cdb_value;
                end
            end
            if (fire)
                valid_d = valid_d & ~sel;
            for (int k = 0; k < RS_SIZE; k++) begin
                if (load_acc && alloc_oh[k]) begin
                    valid_d[k]        = 1'b1;
                    ent_d[k].func     = inst_rs.func;
                    ent_d[k].tag_dest = inst_rs.tag_dest;
                    ent_d[k].tag1     = inst_rs.tag_src1;
                    ent_d[k].tag2     = inst_rs.tag_src2;
                    ent_d[k].rdy1     = inst_rs.ready_src1 || in_wake1;
                    ent_d[k].rdy2     = inst_rs.ready_src2 || in_wake2;
                    ent_d[k].val1     = in_wake1 ? cdb_value : inst_rs.value_src1;
                    ent_d[k].val2     = in_wake2 ? cdb_value : inst_rs.value_src2;
                    ent_d[k].imm      = inst_rs.imm;
                    ent_d[k].pc       = inst_rs.pc;
                    older_d[k]        = valid_q;
                    // A reused slot is younger than everything still resident
                    for (int i = 0; i < RS_SIZE; i++)
                        older_d[i][k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q   <= '0;
            valid_q <= '0;
            older_q <= '0;
        end else begin
            ent_q   <= ent_d;
            valid_q <= valid_d;
            older_q <= older_d;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected issues are queued by the stimulus and popped by a monitor.
module tb_reservation_station;
    import rs_pkg::*;

    typedef struct packed {
        alu_func_t              func;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        src1;
        logic [XLEN-1:0]        src2;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   load = 1'b0;
    inst_rs_t               inst_rs = '0;
    logic                   is_full;
    logic                   cdb_valid = 1'b0;
    logic [ROB_TAG_LEN-1:0] cdb_tag = '0;
    logic [XLEN-1:0]        cdb_value = '0;
    logic                   squash = 1'b0;
    logic                   issue_valid;
    logic                   issue_ready = 1'b0;
    alu_func_t              issue_func;
    logic [ROB_TAG_LEN-1:0] issue_tag;
    logic [XLEN-1:0]        issue_src1, issue_src2, issue_imm, issue_pc;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    reservation_station #(.RS_SIZE(4)) dut (
        .clk(clk), .reset(reset), .load(load), .inst_rs(inst_rs), .is_full(is_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .squash(squash),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_tag(issue_tag), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_imm(issue_imm), .issue_pc(issue_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic inst_rs_t mk(input logic [3:0] func, input logic [4:0] td,
                                    input logic [4:0] t1, input logic r1, input logic [31:0] v1,
                                    input logic [4:0] t2, input logic r2, input logic [31:0] v2);
        inst_rs_t x;
        x            = '0;
        x.func       = func;
        x.tag_dest   = td;
        x.tag_src1   = t1;
        x.ready_src1 = r1;
        x.value_src1 = v1;
        x.tag_src2   = t2;
        x.ready_src2 = r2;
        x.value_src2 = v2;
        x.imm        = 32'h100 + 32'(td);
        x.pc         = 32'h1000 + 32'(td) * 4;
        return x;
    endfunction

    task automatic expect_issue(input inst_rs_t x, input logic [31:0] s1, input logic [31:0] s2);
        exp_t e;
        e.func = x.func;
        e.tag  = x.tag_dest;
        e.src1 = s1;
        e.src2 = s2;
        e.imm  = x.imm;
        e.pc   = x.pc;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input inst_rs_t x);
        inst_rs = x;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    // Monitor: every fire must match the head of the expectation queue
    always @(negedge clk) begin
        if (reset && issue_valid && issue_ready) begin
            exp_t got;
            got = {issue_func, issue_tag, issue_src1, issue_src2, issue_imm, issue_pc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got tag %0d src1 %0h with nothing expected", issue_tag, issue_src1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL issue_payload: got tag %0d src1 %0h src2 %0h expected tag %0d src1 %0h src2 %0h",
                             issue_tag, issue_src1, issue_src2, e.tag, e.src1, e.src2);
                end
            end
        end
    end

    initial begin
        inst_rs_t a, b, f, o, y;
        int wait_cnt;

        // reset state
        #12;
        chk("rst_full", 64'(is_full), 0);
        chk("rst_valid", 64'(issue_valid), 0);
        chk("rst_payload", {issue_tag, issue_src1}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // single ready entry issues next cycle then disappears
        issue_ready = 1'b1;
        a = mk(4'd2, 5'd3, 5'd0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7);
        expect_issue(a, 32'd5, 32'd7);
        do_load(a);
        chk("t1_valid", 64'(issue_valid), 1);
        chk("t1_tag", 64'(issue_tag), 3);
        tick();
        chk("t1_gone", 64'(issue_valid), 0);

        // fill, overflow load ignored, broadcast wakes all in order
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = mk(4'(i), 5'(10 + i), 5'd9, 1'b0, 32'd0, 5'd0, 1'b1, 32'(i + 1));
            expect_issue(b, 32'h42, 32'(i + 1));
            do_load(b);
        end
        chk("fill_full", 64'(is_full), 1);
        do_load(mk(4'd7, 5'd20, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2));
        chk("over_full", 64'(is_full), 1);
        chk("over_noissue", 64'(issue_valid), 0);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'h42; issue_ready = 1'b1;
        tick();
        cdb_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("fill_drained", 64'(exp_q.size()), 0);
        chk("fill_notfull", 64'(is_full), 0);

        // load coinciding with matching broadcast is captured ready
        issue_ready = 1'b0;
        a = mk(4'd1, 5'd4, 5'd0, 1'b1, 32'd1, 5'd6, 1'b0, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'h11;
        do_load(a);
        cdb_valid = 1'b0;
        chk("lw_valid", 64'(issue_valid), 1);
        chk("lw_src2", 64'(issue_src2), 64'h11);
        expect_issue(a, 32'd1, 32'h11);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // two ready entries held back, then issue A before B
        a = mk(4'd3, 5'd1, 5'd0, 1'b1, 32'hA1, 5'd0, 1'b1, 32'hA2);
        b = mk(4'd4, 5'd2, 5'd0, 1'b1, 32'hB1, 5'd0, 1'b1, 32'hB2);
        do_load(a);
        do_load(b);
        for (int i = 0; i < 3; i++) tick();
        chk("hold_tag", 64'(issue_tag), 1);
        expect_issue(a, 32'hA1, 32'hA2);
        expect_issue(b, 32'hB1, 32'hB2);
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;

        // older waiting entry in a higher slot pre-empts younger ready one
        f = mk(4'd5, 5'd11, 5'd0, 1'b1, 32'hF1, 5'd0, 1'b1, 32'hF2);
        o = mk(4'd6, 5'd12, 5'd7, 1'b0, 32'd0, 5'd0, 1'b1, 32'hC2);
        y = mk(4'd8, 5'd13, 5'd0, 1'b1, 32'hD1, 5'd0, 1'b1, 32'hD2);
        do_load(f);
        do_load(o);
        expect_issue(f, 32'hF1, 32'hF2);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        do_load(y);
        chk("age_young_sel", 64'(issue_tag), 13);
        cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h77;
        tick();
        cdb_valid = 1'b0;
        chk("age_old_sel", 64'(issue_tag), 12);
        expect_issue(o, 32'h77, 32'hC2);
        expect_issue(y, 32'hD1, 32'hD2);
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;

        // squash with three entries; same-cycle load dropped
        for (int i = 0; i < 3; i++)
            do_load(mk(4'd1, 5'(20 + i), 5'd0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2));
        squash = 1'b1; issue_ready = 1'b1;
        inst_rs = mk(4'd1, 5'd25, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2);
        load = 1'b1;
        #1;
        chk("sq_valid", 64'(issue_valid), 0);
        tick();
        squash = 1'b0; load = 1'b0;
        chk("sq_full", 64'(is_full), 0);
        chk("sq_empty", 64'(issue_valid), 0);
        tick();
        chk("sq_empty2", 64'(issue_valid), 0);
        issue_ready = 1'b0;

        // wakeup-to-issue timing
        a = mk(4'd9, 5'd14, 5'd2, 1'b0, 32'd0, 5'd0, 1'b1, 32'h33);
        do_load(a);
        expect_issue(a, 32'h99, 32'h33);
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h99; issue_ready = 1'b1;
        #1;
`ifdef RS_WAKEUP_ISSUE_EN
        chk("byp_same", 64'(issue_valid), 1);
`else
        chk("byp_same", 64'(issue_valid), 0);
`endif
        tick();
        cdb_valid = 1'b0;
`ifdef RS_WAKEUP_ISSUE_EN
        chk("byp_next", 64'(issue_valid), 0);
`else
        chk("byp_next", 64'(issue_valid), 1);
`endif
        tick();
        chk("byp_done", 64'(issue_valid), 0);
        issue_ready = 1'b0;

        // asynchronous reset mid-operation, then normal load
        do_load(mk(4'd1, 5'd15, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2));
        do_load(mk(4'd1, 5'd16, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2));
        #2;
        reset = 1'b0;
        #1;
        chk("ares_valid", 64'(issue_valid), 0);
        chk("ares_tag", 64'(issue_tag), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        a = mk(4'd2, 5'd17, 5'd0, 1'b1, 32'h55, 5'd0, 1'b1, 32'h66);
        expect_issue(a, 32'h55, 32'h66);
        do_load(a);
        chk("ares_reload", 64'(issue_tag), 17);
        issue_ready = 1'b1;

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        chk("queue_empty", 64'(exp_q.size()), 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
